huffman_bit_aligner: RTL and testbench
======================================

Name: huffman_bit_aligner

Overview:
- Hardware bitstream front-end for the Huffman decoder.
- Accepts packed IN_W-bit words of encoded data over a valid/ready handshake and holds them in a BUF_W-bit MSB-aligned shift buffer.
- Presents a WIN_W-bit MSB-first look-ahead window to the decoder and discards a variable number of bits per cycle as symbols resolve.
- Handles end-of-stream tail bits, backpressure, over-consume errors and flush.

Parameters:
- IN_W, 32, input word width in bits.
- WIN_W, 10, window width; equals the maximum code length.
- BUF_W, 64, buffer capacity in bits; must satisfy BUF_W >= IN_W + WIN_W - 1.
- LEN_W, 4, width of consume_len; must satisfy 2^LEN_W > WIN_W.
- CNT_W, 7, width of bit_count; must satisfy 2^CNT_W > BUF_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-low.
- flush  in  1  synchronous clear of buffer and stream state.
- in_data  in  IN_W  encoded word; bit IN_W-1 is the earliest bit in the stream.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies the accepted word as the final word of the stream.
- in_ready  out  1  aligner can accept a word this cycle.
- win_data  out  WIN_W  next WIN_W stream bits, MSB = oldest; unfilled LSBs read 0.
- win_valid  out  1  window usable by the decoder.
- consume_en  in  1  decoder discards bits this cycle.
- consume_len  in  LEN_W  number of bits to discard (0..WIN_W).
- bit_count  out  CNT_W  number of valid bits currently buffered.
- stream_done  out  1  last word seen and all bits consumed.
- err_underflow  out  1  sticky over-consume error.

Behaviour:
- State: buf[BUF_W-1:0], cnt, last_seen, done, err. All are registers.
- Reset (rst=0 at clk edge): buf=0, cnt=0, last_seen=0, done=0, err=0. While rst=0, in_ready=0, win_valid=0, bit_count=0, stream_done=0, err_underflow=0.
- Flush: flush=1 clears state identically to reset and has priority over accept and consume in the same cycle. in_ready is forced to 0 while flush=1.
- in_ready is combinational from registered state: rst & ~flush & ~last_seen & (cnt + IN_W <= BUF_W). Consume in the same cycle does not raise in_ready.
- Accept occurs when in_valid & in_ready. in_last is sampled on accept and sets last_seen.
- win_data = buf[BUF_W-1 -: WIN_W].
- win_valid = rst & ((cnt >= WIN_W) | (last_seen & cnt != 0)). The tail case zero-pads the window.
- Consume occurs when consume_en & win_valid. Effective length L = min(consume_len, cnt). consume_en while win_valid=0 is ignored.
- Error: consume_len > cnt or consume_len > WIN_W sets err (sticky until reset or flush). L is clamped to cnt in that case.
- Update order within one cycle: shift buf left by L, then write the accepted word into bit positions [BUF_W-1-(cnt-L) -: IN_W]. Next cnt = cnt - L + (accept ? IN_W : 0).
- Bits below position cnt are always 0. Shifts fill with 0.
- Latency: accepted bits and consumed bits are reflected on win_data and bit_count one cycle later. There is no combinational path from the consume inputs to win_data.
- done is set on the cycle after last_seen & cnt == 0 and holds until reset or flush. After last_seen, further input is refused (in_ready=0).
- Deadlock freedom: the BUF_W constraint guarantees in_ready=1 whenever cnt < WIN_W and last_seen=0.
- Behaviour with parameters that violate the constraints is not defined; RTL shall flag them with an elaboration-time check.

Test Plan (IN_W=8, WIN_W=6, BUF_W=16, LEN_W=3, CNT_W=5):
1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=0, win_valid=0, bit_count=0, stream_done=0, err_underflow=0. Release rst -> in_ready=1 on the same cycle.
2. Basic consume: push 8'hB5 -> next cycle bit_count=8, win_valid=1, win_data=6'b101101. Then consume_len=4 -> bit_count=4, win_valid=0, win_data=6'b010100.
3. Simultaneous accept and consume: buffer holds 10110101 (cnt=8); push 8'h0F with consume_len=1 in one cycle -> bit_count=15, win_data=6'b011010, bit_count then shows 15.
4. Backpressure: with cnt=10, in_valid=1 -> in_ready=0 and the word is held. Consume 2 -> cnt=8, and in_ready=1 the following cycle; the word is accepted.
5. Tail and done: push 8'hC0 with in_last=1 -> in_ready=0 afterward. Consume 6 -> cnt=2, win_valid=1, win_data=0. Consume 2 -> cnt=0, win_valid=0, stream_done=1 one cycle later.
6. Underflow and flush: in tail with cnt=2, consume_len=5 -> err_underflow=1, bit_count=0, stream_done=1. Assert flush with in_valid=1 -> word dropped, err_underflow=0, stream_done=0, bit_count=0.

Source files
------------

// File: rtl/huffman_bit_aligner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | huffman_bit_aligner_if: word input, look-ahead window and status   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface huffman_bit_aligner_if #(
  parameter int IN_W  = 32,
  parameter int WIN_W = 10,
  parameter int LEN_W = 4,
  parameter int CNT_W = 7
);
  logic             flush;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic             consume_en;
  logic [LEN_W-1:0] consume_len;
  logic [CNT_W-1:0] bit_count;
  logic             stream_done;
  logic             err_underflow;

  modport master (
    output flush, in_data, in_valid, in_last, consume_en, consume_len,
    input  in_ready, win_data, win_valid, bit_count, stream_done, err_underflow
  );

  modport slave (
    input  flush, in_data, in_valid, in_last, consume_en, consume_len,
    output in_ready, win_data, win_valid, bit_count, stream_done, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/huffman_bit_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | huffman_bit_aligner: MSB-aligned bit buffer feeding a Huffman      |
// | decoder with a WIN_W-bit window and variable per-cycle consume.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module huffman_bit_aligner #(
  parameter int IN_W  = 32,
  parameter int WIN_W = 10,
  parameter int BUF_W = 64,
  parameter int LEN_W = 4,
  parameter int CNT_W = 7
) (
  input logic                  clk,
  input logic                  rst,
  huffman_bit_aligner_if.slave bus
);

  localparam logic [CNT_W-1:0] c_in_w  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] c_win_w = CNT_W'(WIN_W);
  localparam logic [CNT_W-1:0] c_room  = CNT_W'(BUF_W - IN_W);

  generate
    if ((BUF_W < IN_W + WIN_W - 1) || ((1 << LEN_W) <= WIN_W) ||
        ((1 << CNT_W) <= BUF_W)) begin : g_bad_params
      $error("huffman_bit_aligner: illegal IN_W/WIN_W/BUF_W/LEN_W/CNT_W combination");
    end
  endgenerate

  logic [BUF_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_seen_q, last_seen_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             w_in_ready;
  logic             w_win_valid;
  logic             w_accept;
  logic             w_consume;
  logic             w_over;
  logic [CNT_W-1:0] w_len_ext;
  logic [CNT_W-1:0] w_len_eff;
  logic [BUF_W-1:0] w_word;

  always_comb begin
    w_in_ready  = rst & ~bus.flush & ~last_seen_q & (cnt_q <= c_room);
    w_win_valid = rst & ((cnt_q >= c_win_w) | (last_seen_q & (cnt_q != '0)));
    w_accept    = bus.in_valid & w_in_ready;
    w_consume   = bus.consume_en & w_win_valid;
    w_len_ext   = CNT_W'(bus.consume_len);
    w_over      = w_consume & ((w_len_ext > cnt_q) | (w_len_ext > c_win_w));
    w_len_eff   = w_consume ? ((w_len_ext > cnt_q) ? cnt_q : w_len_ext) : '0;
    w_word      = BUF_W'(bus.in_data) << (BUF_W - IN_W);
  end

  always_comb begin
    shift_d     = shift_q << w_len_eff;
    cnt_d       = cnt_q - w_len_eff;
    last_seen_d = last_seen_q;
    done_d      = done_q | (last_seen_q & (cnt_q == '0));
    err_d       = err_q | w_over;
    if (w_accept) begin
      // New word lands directly under the bits that survive this cycle's consume.
      shift_d     = shift_d | (w_word >> cnt_d);
      cnt_d       = cnt_d + c_in_w;
      last_seen_d = bus.in_last;
    end
    if (!rst || bus.flush) begin
      shift_d     = '0;
      cnt_d       = '0;
      last_seen_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    shift_q     <= shift_d;
    cnt_q       <= cnt_d;
    last_seen_q <= last_seen_d;
    done_q      <= done_d;
    err_q       <= err_d;
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.win_valid     = w_win_valid;
  assign bus.win_data      = shift_q[BUF_W-1 -: WIN_W];
  assign bus.bit_count     = rst ? cnt_q : '0;
  assign bus.stream_done   = rst & done_q;
  assign bus.err_underflow = rst & err_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_bit_aligner.sv
`default_nettype none
// Bench for huffman_bit_aligner: directed scenarios plus a random run
// checked against a bit-queue model of the stream.
module tb_huffman_bit_aligner;
  localparam int IN_W = 8, WIN_W = 6, BUF_W = 16, LEN_W = 3, CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  huffman_bit_aligner_if #(.IN_W(IN_W), .WIN_W(WIN_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  huffman_bit_aligner #(
    .IN_W(IN_W), .WIN_W(WIN_W), .BUF_W(BUF_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  bit mq[$];
  bit m_last, m_done, m_err;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush = 0; bus.in_valid = 0; bus.in_last = 0; bus.in_data = '0;
    bus.consume_en = 0; bus.consume_len = '0;
  endtask

  task automatic do_flush;
    bus.flush = 1; tick; bus.flush = 0;
  endtask

  task automatic push(input logic [IN_W-1:0] d, input logic last);
    bus.in_data = d; bus.in_valid = 1; bus.in_last = last;
    tick;
    bus.in_valid = 0; bus.in_last = 0;
  endtask

  task automatic consume(input int n);
    bus.consume_en = 1; bus.consume_len = LEN_W'(n);
    tick;
    bus.consume_en = 0; bus.consume_len = '0;
  endtask

  task automatic test_reset;
    rst = 0; bus.in_valid = 1; bus.in_data = 8'hAA;
    tick; tick;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid: got %b want 0", bus.win_valid); end
    total++; if (bus.bit_count !== 5'd0) begin bad++; $display("FAIL reset_bit_count: got %0d want 0", bus.bit_count); end
    total++; if (bus.stream_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.stream_done); end
    total++; if (bus.err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err_underflow); end
    rst = 1; bus.in_valid = 0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
    tick;
  endtask

  task automatic test_basic_consume;
    push(8'hB5, 0);
    total++; if (bus.bit_count !== 5'd8) begin bad++; $display("FAIL basic_count8: got %0d want 8", bus.bit_count); end
    total++; if (bus.win_valid !== 1'b1) begin bad++; $display("FAIL basic_wv1: got %b want 1", bus.win_valid); end
    total++; if (bus.win_data !== 6'b101101) begin bad++; $display("FAIL basic_win1: got %b want 101101", bus.win_data); end
    consume(4);
    total++; if (bus.bit_count !== 5'd4) begin bad++; $display("FAIL basic_count4: got %0d want 4", bus.bit_count); end
    total++; if (bus.win_valid !== 1'b0) begin bad++; $display("FAIL basic_wv0: got %b want 0", bus.win_valid); end
    total++; if (bus.win_data !== 6'b010100) begin bad++; $display("FAIL basic_win2: got %b want 010100", bus.win_data); end
    do_flush;
  endtask

  task automatic test_simultaneous;
    push(8'hB5, 0);
    bus.in_data = 8'h0F; bus.in_valid = 1; bus.consume_en = 1; bus.consume_len = 3'd1;
    tick;
    idle_inputs;
    total++; if (bus.bit_count !== 5'd15) begin bad++; $display("FAIL simul_count: got %0d want 15", bus.bit_count); end
    total++; if (bus.win_data !== 6'b011010) begin bad++; $display("FAIL simul_win: got %b want 011010", bus.win_data); end
    tick;
    total++; if (bus.bit_count !== 5'd15) begin bad++; $display("FAIL simul_hold: got %0d want 15", bus.bit_count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL simul_full_ready: got %b want 0", bus.in_ready); end
    do_flush;
  endtask

  task automatic test_backpressure;
    push(8'hB5, 0);
    push(8'h0F, 0);
    consume(6);
    bus.in_data = 8'h3C; bus.in_valid = 1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready10: got %b want 0", bus.in_ready); end
    total++; if (bus.bit_count !== 5'd10) begin bad++; $display("FAIL bp_count10: got %0d want 10", bus.bit_count); end
    tick;
    total++; if (bus.bit_count !== 5'd10) begin bad++; $display("FAIL bp_held: got %0d want 10", bus.bit_count); end
    bus.consume_en = 1; bus.consume_len = 3'd2;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_consume_no_ready: got %b want 0", bus.in_ready); end
    tick;
    bus.consume_en = 0; bus.consume_len = '0;
    total++; if (bus.bit_count !== 5'd8) begin bad++; $display("FAIL bp_count8: got %0d want 8", bus.bit_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready8: got %b want 1", bus.in_ready); end
    tick;
    bus.in_valid = 0;
    total++; if (bus.bit_count !== 5'd16) begin bad++; $display("FAIL bp_count16: got %0d want 16", bus.bit_count); end
    total++; if (bus.win_data !== 6'b000011) begin bad++; $display("FAIL bp_win: got %b want 000011", bus.win_data); end
    do_flush;
  endtask

  task automatic test_tail_done;
    push(8'hC0, 1);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL tail_ready: got %b want 0", bus.in_ready); end
    consume(6);
    total++; if (bus.bit_count !== 5'd2) begin bad++; $display("FAIL tail_count2: got %0d want 2", bus.bit_count); end
    total++; if (bus.win_valid !== 1'b1) begin bad++; $display("FAIL tail_wv: got %b want 1", bus.win_valid); end
    total++; if (bus.win_data !== 6'b000000) begin bad++; $display("FAIL tail_win: got %b want 000000", bus.win_data); end
    consume(2);
    total++; if (bus.bit_count !== 5'd0) begin bad++; $display("FAIL tail_count0: got %0d want 0", bus.bit_count); end
    total++; if (bus.win_valid !== 1'b0) begin bad++; $display("FAIL tail_wv0: got %b want 0", bus.win_valid); end
    total++; if (bus.stream_done !== 1'b0) begin bad++; $display("FAIL tail_done_early: got %b want 0", bus.stream_done); end
    tick;
    total++; if (bus.stream_done !== 1'b1) begin bad++; $display("FAIL tail_done: got %b want 1", bus.stream_done); end
    do_flush;
  endtask

  task automatic test_underflow_flush;
    push(8'hC0, 1);
    consume(6);
    consume(5);
    total++; if (bus.err_underflow !== 1'b1) begin bad++; $display("FAIL uf_err: got %b want 1", bus.err_underflow); end
    total++; if (bus.bit_count !== 5'd0) begin bad++; $display("FAIL uf_count: got %0d want 0", bus.bit_count); end
    tick;
    total++; if (bus.stream_done !== 1'b1) begin bad++; $display("FAIL uf_done: got %b want 1", bus.stream_done); end
    bus.flush = 1; bus.in_valid = 1; bus.in_data = 8'hFF;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
    tick;
    bus.flush = 0; bus.in_valid = 0;
    #1;
    total++; if (bus.err_underflow !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", bus.err_underflow); end
    total++; if (bus.stream_done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b want 0", bus.stream_done); end
    total++; if (bus.bit_count !== 5'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", bus.bit_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_random(input int n_cycles);
    idle_inputs;
    do_flush;
    mq.delete(); m_last = 0; m_done = 0; m_err = 0;
    for (int c = 0; c < n_cycles; c++) begin
      int sz, len, n;
      bit m_ready, wv, nd;
      logic [WIN_W-1:0] ew;
      bus.flush       = m_done || ($urandom_range(0, 59) == 0);
      bus.in_valid    = ($urandom_range(0, 2) != 0);
      bus.in_data     = IN_W'($urandom);
      bus.in_last     = ($urandom_range(0, 24) == 0);
      bus.consume_en  = ($urandom_range(0, 1) == 1);
      len             = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, WIN_W));
      bus.consume_len = LEN_W'(len);
      #1;
      sz      = mq.size();
      m_ready = !bus.flush && !m_last && (sz + IN_W <= BUF_W);
      total++; if (bus.in_ready !== m_ready) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.in_ready, m_ready); end
      if (bus.flush) begin
        mq.delete(); m_last = 0; m_done = 0; m_err = 0;
      end else begin
        wv = (sz >= WIN_W) || (m_last && sz != 0);
        nd = m_done || (m_last && sz == 0);
        if (bus.consume_en && wv) begin
          if (len > sz || len > WIN_W) m_err = 1;
          n = (len < sz) ? len : sz;
          repeat (n) void'(mq.pop_front());
        end
        if (bus.in_valid && m_ready) begin
          for (int i = IN_W - 1; i >= 0; i--) mq.push_back(bus.in_data[i]);
          if (bus.in_last) m_last = 1;
        end
        m_done = nd;
      end
      tick;
      sz = mq.size();
      for (int i = 0; i < WIN_W; i++) ew[WIN_W-1-i] = (i < sz) ? mq[i] : 1'b0;
      wv = (sz >= WIN_W) || (m_last && sz != 0);
      total++; if (bus.bit_count !== CNT_W'(sz)) begin bad++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, bus.bit_count, sz); end
      total++; if (bus.win_data !== ew) begin bad++; $display("FAIL rnd_win c=%0d: got %b want %b", c, bus.win_data, ew); end
      total++; if (bus.win_valid !== wv) begin bad++; $display("FAIL rnd_wv c=%0d: got %b want %b", c, bus.win_valid, wv); end
      total++; if (bus.stream_done !== m_done) begin bad++; $display("FAIL rnd_done c=%0d: got %b want %b", c, bus.stream_done, m_done); end
      total++; if (bus.err_underflow !== m_err) begin bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, bus.err_underflow, m_err); end
    end
    idle_inputs;
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_basic_consume;
    test_simultaneous;
    test_backpressure;
    test_tail_done;
    test_underflow_flush;
    test_random(800);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
